// File: rtl/alu_collector_pkg.sv
// rtl/alu_collector_pkg.sv - shared types and operand-requirement decode for the ALU operand collector
//
// Purpose : collector state encoding, operand-requirement codes and the
//           op_req() function that maps (mode, cmd) to the operands a
//           command consumes.
// Ports   : none (package).

package alu_collector_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_A = 2'd1,   // holding B, waiting for A
      WAIT_B = 2'd2    // holding A, waiting for B
   } state_t;

   // Operand requirement codes, same bit meaning as inp_valid (bit0 = A, bit1 = B)
   localparam logic [1:0] REQ_A  = 2'b01;
   localparam logic [1:0] REQ_B  = 2'b10;
   localparam logic [1:0] REQ_AB = 2'b11;

   // Arithmetic-mode single-operand commands
   localparam logic [31:0] ARITH_NEED_A_0 = 32'd4;
   localparam logic [31:0] ARITH_NEED_A_1 = 32'd5;
   localparam logic [31:0] ARITH_NEED_B_0 = 32'd6;
   localparam logic [31:0] ARITH_NEED_B_1 = 32'd7;

   // Logical-mode single-operand commands
   localparam logic [31:0] LOGIC_NEED_A_0 = 32'd6;
   localparam logic [31:0] LOGIC_NEED_A_1 = 32'd8;
   localparam logic [31:0] LOGIC_NEED_A_2 = 32'd9;
   localparam logic [31:0] LOGIC_NEED_B_0 = 32'd7;
   localparam logic [31:0] LOGIC_NEED_B_1 = 32'd10;
   localparam logic [31:0] LOGIC_NEED_B_2 = 32'd11;

   // Returns which operands a command consumes; anything not listed needs both
   function automatic logic [1:0] op_req(input logic mode, input logic [31:0] cmd);
      logic [1:0] r;
      r = REQ_AB;
      if (mode) begin
         if (cmd == ARITH_NEED_A_0 || cmd == ARITH_NEED_A_1)
            r = REQ_A;
         else if (cmd == ARITH_NEED_B_0 || cmd == ARITH_NEED_B_1)
            r = REQ_B;
      end else begin
         if (cmd == LOGIC_NEED_A_0 || cmd == LOGIC_NEED_A_1 || cmd == LOGIC_NEED_A_2)
            r = REQ_A;
         else if (cmd == LOGIC_NEED_B_0 || cmd == LOGIC_NEED_B_1 || cmd == LOGIC_NEED_B_2)
            r = REQ_B;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_operand_req_decode.sv
// rtl/alu_operand_req_decode.sv - combinational operand-requirement decoder
//
// Purpose : thin combinational wrapper around op_req() so the requirement
//           decode can be instantiated wherever it is needed.
// Ports   : i_mode  - 1 = arithmetic, 0 = logical
//           i_cmd   - command code
//           o_req   - required operands (bit0 = A, bit1 = B)

module alu_operand_req_decode
   import alu_collector_pkg::*;
#(
   parameter int CMD_WIDTH = 4
) (
   input  logic                 i_mode,
   input  logic [CMD_WIDTH-1:0] i_cmd,
   output logic [1:0]           o_req
);

   assign o_req = op_req(i_mode, 32'(i_cmd));

endmodule

// File: rtl/alu_operand_collector.sv
// rtl/alu_operand_collector.sv - pairs split operands and issues complete registered ALU requests
//
// Purpose : accepts operands that may arrive in separate cycles, pairs them
//           within a TIMEOUT-cycle window and issues one registered operation
//           to the ALU. An expired or impossible partial request is dropped
//           with a one-cycle timeout_err pulse and a saturating count.
// Ports   : clk, RST_N (async, active-low), CE (clock enable)
//           in_opa/in_opb/in_inp_valid/in_cmd/in_mode/in_cin - source side
//           OPA/OPB/CMD/mode/Cin/inp_valid                  - ALU side
//           busy        - partial operation held
//           timeout_err - pulse on dropped partial request
//           timeout_cnt - saturating count of timeouts

module alu_operand_collector
   import alu_collector_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CMD_WIDTH    = 4,
   parameter int TIMEOUT      = 16,
   parameter int ERRCNT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    RST_N,
   input  logic                    CE,
   input  logic [DATA_WIDTH-1:0]   in_opa,
   input  logic [DATA_WIDTH-1:0]   in_opb,
   input  logic [1:0]              in_inp_valid,
   input  logic [CMD_WIDTH-1:0]    in_cmd,
   input  logic                    in_mode,
   input  logic                    in_cin,
   output logic [DATA_WIDTH-1:0]   OPA,
   output logic [DATA_WIDTH-1:0]   OPB,
   output logic [CMD_WIDTH-1:0]    CMD,
   output logic                    mode,
   output logic                    Cin,
   output logic [1:0]              inp_valid,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [ERRCNT_WIDTH-1:0] timeout_cnt
);

   localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

   state_t                  r_state;
   logic [WCW-1:0]          r_wait_cnt;

   // Partial operation held while waiting for the partner operand
   logic [DATA_WIDTH-1:0]   r_hold_opa;
   logic [DATA_WIDTH-1:0]   r_hold_opb;
   logic [CMD_WIDTH-1:0]    r_hold_cmd;
   logic                    r_hold_mode;
   logic                    r_hold_cin;

   // Registered outputs
   logic [DATA_WIDTH-1:0]   r_opa;
   logic [DATA_WIDTH-1:0]   r_opb;
   logic [CMD_WIDTH-1:0]    r_cmd;
   logic                    r_mode;
   logic                    r_cin;
   logic [1:0]              r_inp_valid;
   logic                    r_busy;
   logic                    r_timeout_err;
   logic [ERRCNT_WIDTH-1:0] r_timeout_cnt;

   logic [1:0]              w_req;
   logic                    w_partner;
   logic [ERRCNT_WIDTH-1:0] w_tcnt_next;

   alu_operand_req_decode #(
      .CMD_WIDTH (CMD_WIDTH)
   ) u_req_decode (
      .i_mode (in_mode),
      .i_cmd  (in_cmd),
      .o_req  (w_req)
   );

   // In WAIT_B the partner is B (bit1); in WAIT_A it is A (bit0)
   assign w_partner   = (r_state == WAIT_B) ? in_inp_valid[1] : in_inp_valid[0];
   assign w_tcnt_next = (&r_timeout_cnt) ? r_timeout_cnt : r_timeout_cnt + 1'b1;

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         r_state       <= IDLE;
         r_wait_cnt    <= '0;
         r_hold_opa    <= '0;
         r_hold_opb    <= '0;
         r_hold_cmd    <= '0;
         r_hold_mode   <= 1'b0;
         r_hold_cin    <= 1'b0;
         r_opa         <= '0;
         r_opb         <= '0;
         r_cmd         <= '0;
         r_mode        <= 1'b0;
         r_cin         <= 1'b0;
         r_inp_valid   <= 2'b00;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_timeout_cnt <= '0;
      end else if (CE) begin
         // Pulses only last one CE cycle
         r_inp_valid   <= 2'b00;
         r_timeout_err <= 1'b0;

         case (r_state)
            IDLE: begin
               if (in_inp_valid != 2'b00) begin
                  if (in_inp_valid == REQ_AB || in_inp_valid == w_req) begin
                     // Everything the command needs is here: issue directly
                     r_opa       <= in_opa;
                     r_opb       <= in_opb;
                     r_cmd       <= in_cmd;
                     r_mode      <= in_mode;
                     r_cin       <= in_cin;
                     r_inp_valid <= in_inp_valid;
                  end else if (w_req == REQ_AB) begin
                     // Half of a two-operand command: hold it and wait
                     r_hold_opa  <= in_opa;
                     r_hold_opb  <= in_opb;
                     r_hold_cmd  <= in_cmd;
                     r_hold_mode <= in_mode;
                     r_hold_cin  <= in_cin;
                     r_wait_cnt  <= '0;
                     r_busy      <= 1'b1;
                     r_state     <= (in_inp_valid == REQ_A) ? WAIT_B : WAIT_A;
                  end else begin
                     // Wrong single operand for a single-operand command
                     r_timeout_err <= 1'b1;
                     r_timeout_cnt <= w_tcnt_next;
                  end
               end
            end

            WAIT_A, WAIT_B: begin
               if (w_partner) begin
                  // Partner wins even on the expiry cycle
                  r_opa       <= (r_state == WAIT_B) ? r_hold_opa : in_opa;
                  r_opb       <= (r_state == WAIT_B) ? in_opb : r_hold_opb;
                  r_cmd       <= r_hold_cmd;
                  r_mode      <= r_hold_mode;
                  r_cin       <= r_hold_cin;
                  r_inp_valid <= REQ_AB;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end else if (r_wait_cnt == LAST_WAIT) begin
                  r_timeout_err <= 1'b1;
                  r_timeout_cnt <= w_tcnt_next;
                  r_busy        <= 1'b0;
                  r_state       <= IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign OPA         = r_opa;
   assign OPB         = r_opb;
   assign CMD         = r_cmd;
   assign mode        = r_mode;
   assign Cin         = r_cin;
   assign inp_valid   = r_inp_valid;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;
   assign timeout_cnt = r_timeout_cnt;

endmodule
